tb_rdout: RTL and testbench



---
 rtl/tb_rdout.sv | 102 ++++++++++
 tb/tb_tb_rdout.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_rdout.sv
// Monitor-vector readout: on a change of monitor_i, writes a framed packet
// (header + ceil(K/N) data words, LSB slice first) into a downstream FIFO.
module tb_rdout #(
    parameter int unsigned N = 32,
    parameter int unsigned K = 576
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [K-1:0] monitor_i,
    input  logic         fifo_full_i,
    input  logic         fifo_almst_full_i,
    output logic         fifo_wr_o,
    output logic [N-1:0] fifo_data_o
);

    localparam int unsigned W  = (K + N - 1) / N;
    localparam int unsigned KP = W * N;
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned FW = N - 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [K-1:0]    last_r;
    logic [K-1:0]    snap_r;
    logic [IW-1:0]   idx_r;
    logic [FW-1:0]   fcnt_r;

    logic            start;
    logic            last_word;
    logic [KP-1:0]   snap_pad;
    logic [N-1:0]    data_word;

    // Zero-pad the snapshot so the final word reads 0 beyond bit K-1
    assign snap_pad  = KP'(snap_r);
    assign data_word = N'(snap_pad >> (int'(idx_r) * N));
    assign last_word = (idx_r == IW'(W - 1));

    // Next-state and FIFO strike/data decode
    always_comb begin
        state_nx    = state;
        start       = 1'b0;
        fifo_wr_o   = 1'b0;
        fifo_data_o = '0;
        if (state != IDLE) begin
            fifo_wr_o = !fifo_full_i;
        end
        case (state)
            IDLE: begin
                if ((monitor_i != last_r) && !fifo_almst_full_i) begin
                    start    = 1'b1;
                    state_nx = HDR;
                end
            end
            HDR: begin
                fifo_data_o = {8'hA5, fcnt_r};
                if (fifo_wr_o) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                fifo_data_o = data_word;
                if (fifo_wr_o && last_word) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, snapshot, word index and frame counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            last_r <= '0;
            snap_r <= '0;
            idx_r  <= '0;
            fcnt_r <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                snap_r <= monitor_i;
                last_r <= monitor_i;
                idx_r  <= '0;
            end
            if ((state == HDR) && fifo_wr_o) begin
                fcnt_r <= fcnt_r + FW'(1);
            end
            if ((state == DATA) && fifo_wr_o) begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tb_rdout.sv
// Scoreboard bench for tb_rdout: a default instance (N=32, K=576) and a
// small instance (N=32, K=40) share clock and reset.
module tb_tb_rdout;

    typedef struct packed {
        logic        hdr;
        logic [31:0] d;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [575:0] mon_a;
    logic         full_a, afull_a;
    logic         wr_a;
    logic [31:0]  data_a;
    logic [39:0]  mon_b;
    logic         wr_b;
    logic [31:0]  data_b;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   fa = 0, fb = 0;
    int   nwr_a = 0, nwr_b = 0;
    int   hdr_cyc_a = 0, last_wr_a = 0;
    int   hdr_cyc_b = 0, last_wr_b = 0;

    tb_rdout #(.N(32), .K(576)) dut_a (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .monitor_i        (mon_a),
        .fifo_full_i      (full_a),
        .fifo_almst_full_i(afull_a),
        .fifo_wr_o        (wr_a),
        .fifo_data_o      (data_a)
    );

    tb_rdout #(.N(32), .K(40)) dut_b (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .monitor_i        (mon_b),
        .fifo_full_i      (1'b0),
        .fifo_almst_full_i(1'b0),
        .fifo_wr_o        (wr_b),
        .fifo_data_o      (data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop expected word on every write strike
    always @(negedge clk) begin
        if (wr_a) begin
            chk("wr_while_full_a", 64'(full_a), 64'd0);
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_wr_a act=%0h exp=none (cyc %0d)", data_a, cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("word_a", 64'(data_a), 64'(e.d));
                if (e.hdr) hdr_cyc_a = cyc;
            end
            last_wr_a = cyc;
            nwr_a++;
        end
    end

    always @(negedge clk) begin
        if (wr_b) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_wr_b act=%0h exp=none (cyc %0d)", data_b, cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("word_b", 64'(data_b), 64'(e.d));
                if (e.hdr) hdr_cyc_b = cyc;
            end
            last_wr_b = cyc;
            nwr_b++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [575:0] v);
        qa.push_back('{hdr: 1'b1, d: {8'hA5, 24'(fa)}});
        fa++;
        for (int i = 0; i < 18; i++) qa.push_back('{hdr: 1'b0, d: v[i*32 +: 32]});
    endtask

    task automatic push_b(input logic [39:0] v);
        qb.push_back('{hdr: 1'b1, d: {8'hA5, 24'(fb)}});
        fb++;
        qb.push_back('{hdr: 1'b0, d: v[31:0]});
        qb.push_back('{hdr: 1'b0, d: {24'h0, v[39:32]}});
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 400) begin
            tick(1);
            k++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_%s act=%0d exp=0 words pending", nm, qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
        tick(2);
    endtask

    initial begin
        int t0, t1, n0, bad;
        logic [575:0] v;

        rst_n   = 1'b0;
        mon_a   = '0;
        mon_b   = '0;
        full_a  = 1'b0;
        afull_a = 1'b0;
        tick(3);
        chk("rst_wr_a", 64'(wr_a), 64'd0);
        chk("rst_data_a", 64'(data_a), 64'd0);
        chk("rst_wr_b", 64'(wr_b), 64'd0);
        rst_n = 1'b1;

        // Quiet monitor produces nothing
        n0  = nwr_a;
        bad = 0;
        repeat (100) begin
            tick(1);
            if (wr_a || data_a != 32'h0) bad++;
        end
        chk("idle_quiet_a", 64'(bad), 64'd0);
        chk("idle_nwr_a", 64'(nwr_a - n0), 64'd0);

        // Bit 0 and bit 575: words 0 and 17 non-zero
        v      = '0;
        v[0]   = 1'b1;
        v[575] = 1'b1;
        mon_a  = v;
        push_a(v);
        t0 = cyc;
        n0 = nwr_a;
        drain("basic");
        chk("basic_hdr_cyc", 64'(hdr_cyc_a), 64'(t0 + 1));
        chk("basic_last_cyc", 64'(last_wr_a), 64'(t0 + 19));
        chk("basic_count", 64'(nwr_a - n0), 64'd19);

        // Second change: header counter = 1
        v[32]  = 1'b1;
        mon_a  = v;
        push_a(v);
        drain("second");

        // fifo_full for 5 cycles at word 7
        v[7*32 +: 32] = 32'hDEADBEEF;
        mon_a = v;
        push_a(v);
        t0 = cyc;
        n0 = nwr_a;
        tick(9);
        full_a = 1'b1;
        tick(5);
        full_a = 1'b0;
        drain("stall");
        chk("stall_last_cyc", 64'(last_wr_a), 64'(t0 + 24));
        chk("stall_count", 64'(nwr_a - n0), 64'd19);

        // Almost-full defers the frame start
        afull_a = 1'b1;
        v[31:0] = 32'hCAFEF00D;
        mon_a   = v;
        push_a(v);
        n0 = nwr_a;
        tick(10);
        chk("afull_block", 64'(nwr_a - n0), 64'd0);
        afull_a = 1'b0;
        t1 = cyc;
        drain("afull");
        chk("afull_hdr_cyc", 64'(hdr_cyc_a), 64'(t1 + 1));

        // Change during a frame: old snapshot, then new frame after one idle cycle
        v[3*32 +: 32] = 32'h11112222;
        mon_a = v;
        push_a(v);
        t0 = cyc;
        tick(5);
        v[3*32 +: 32] = 32'h33334444;
        mon_a = v;
        push_a(v);
        drain("coalesce");
        chk("coal_hdr_cyc", 64'(hdr_cyc_a), 64'(t0 + 21));
        chk("coal_last_cyc", 64'(last_wr_a), 64'(t0 + 39));

        // Small instance: K=40, two data words with zero-padded tail
        mon_b = 40'hFF_12345678;
        push_b(40'hFF_12345678);
        t0 = cyc;
        n0 = nwr_b;
        drain("k40");
        chk("k40_hdr_cyc", 64'(hdr_cyc_b), 64'(t0 + 1));
        chk("k40_last_cyc", 64'(last_wr_b), 64'(t0 + 3));
        chk("k40_count", 64'(nwr_b - n0), 64'd3);

        // Reset right after the header aborts the frame
        mon_b = 40'h0A_A5A5A5A5;
        qb.push_back('{hdr: 1'b1, d: {8'hA5, 24'(fb)}});
        tick(1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        mon_a = '0;
        mon_b = '0;
        fa    = 0;
        fb    = 0;
        #1;
        chk("abort_wr_b", 64'(wr_b), 64'd0);
        chk("abort_data_b", 64'(data_b), 64'd0);
        chk("abort_hdr_seen", 64'(qb.size()), 64'd0);
        tick(3);
        rst_n = 1'b1;
        n0 = nwr_b;
        tick(20);
        chk("abort_no_wr", 64'(nwr_b - n0), 64'd0);

        // Frame counter restarts from zero after reset
        mon_b = 40'h00_00000001;
        push_b(40'h00_00000001);
        drain("post_rst");
        chk("post_rst_data_a", 64'(data_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
